// File: rtl/ddc_pkg.sv
// Shared constants and elaboration-time helpers for the NCO down-converter:
// width derivation, quadrant codes and the quarter-wave sine table generator.
package ddc_pkg;

   localparam logic [1:0] QUAD_0 = 2'd0;
   localparam logic [1:0] QUAD_1 = 2'd1;
   localparam logic [1:0] QUAD_2 = 2'd2;
   localparam logic [1:0] QUAD_3 = 2'd3;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   function automatic int prod_w(input int data_w, input int lo_w);
      return data_w + lo_w;
   endfunction

   function automatic int out_w(input int data_w, input int lo_w, input int dec);
      return data_w + lo_w + clog2(dec);
   endfunction

   // round(peak*sin(pi*k/(2*2^aw))); Taylor series is exact to well below
   // one LSB over the first quadrant.
   function automatic int tq_val(input int k, input int aw, input int lo_w);
      real x, term, s;
      int  peak;
      peak = (1 << (lo_w - 1)) - 1;
      x    = 3.14159265358979323846 * k / (2.0 * (1 << aw));
      term = x;
      s    = x;
      for (int n = 1; n < 12; n++) begin
         term = -term * x * x / ((2 * n) * (2 * n + 1));
         s    = s + term;
      end
      return $rtoi(peak * s + 0.5);
   endfunction

endpackage

// File: rtl/ddc_nco_mixer_sincos_lut.sv
// Combinational quarter-wave sin/cos lookup; the full cycle is rebuilt by
// folding the two phase MSBs (quadrant) onto a single positive table.
module ddc_sincos_lut
   import ddc_pkg::*;
#(
   parameter int PHASE_W = 16,
   parameter int LUT_AW  = 6,
   parameter int LO_W    = 8
) (
   input  logic        [PHASE_W-1:0] phase,
   output logic signed [LO_W-1:0]    cos_o,
   output logic signed [LO_W-1:0]    sin_o
);

   localparam int N = 1 << LUT_AW;

   logic signed [LO_W-1:0] tq [0:N];
   logic        [1:0]      quad;
   logic        [LUT_AW:0] k, kn;
   logic signed [LO_W-1:0] a, b;

   for (genvar i = 0; i <= N; i++) begin : g_tq
      assign tq[i] = LO_W'(tq_val(i, LUT_AW, LO_W));
   end

   if (PHASE_W > LUT_AW + 2) begin : g_trunc
      logic unused_lo;
      assign unused_lo = ^phase[PHASE_W-LUT_AW-3:0];
   end

   assign quad = phase[PHASE_W-1 -: 2];
   assign k    = {1'b0, phase[PHASE_W-3 -: LUT_AW]};
   assign kn   = (LUT_AW+1)'(N) - k;
   assign a    = tq[k];
   assign b    = tq[kn];

   always_comb begin
      case (quad)
         QUAD_0:  begin sin_o = a;  cos_o = b;  end
         QUAD_1:  begin sin_o = b;  cos_o = -a; end
         QUAD_2:  begin sin_o = -a; cos_o = -b; end
         default: begin sin_o = -b; cos_o = a;  end
      endcase
   end

endmodule

// File: rtl/ddc_nco_mixer.sv
// Pipelined down-converter: NCO phase -> LUT (stage 1), IF x LO products
// (stage 2), accumulate-and-dump over DEC samples (stage 3).
module ddc_nco_mixer
   import ddc_pkg::*;
#(
   parameter  int DATA_W  = 8,
   parameter  int LO_W    = 8,
   parameter  int PHASE_W = 16,
   parameter  int LUT_AW  = 6,
   parameter  int DEC     = 4,
   localparam int OUT_W   = out_w(DATA_W, LO_W, DEC)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic signed [DATA_W-1:0]  if_in,
   input  logic        [PHASE_W-1:0] phase_inc,
   input  logic                      freq_load,
   input  logic                      sync,
   output logic signed [OUT_W-1:0]   I_out,
   output logic signed [OUT_W-1:0]   Q_out,
   output logic                      out_valid
);

   localparam int PW    = prod_w(DATA_W, LO_W);
   localparam int CNT_W = (clog2(DEC) > 0) ? clog2(DEC) : 1;

   logic        [PHASE_W-1:0] phase, phase_acc_d, phase_acc_q, phase_inc_r_d, phase_inc_r_q;
   logic signed [LO_W-1:0]    lut_cos, lut_sin, cos1_d, cos1_q, sin1_d, sin1_q;
   logic signed [DATA_W-1:0]  if1_d, if1_q;
   logic                      first1_d, first1_q, first2_d, first2_q;
   logic                      v1_d, v1_q, v2_d, v2_q, out_valid_d, out_valid_q;
   logic signed [PW-1:0]      pi2_d, pi2_q, pq2_d, pq2_q;
   logic signed [OUT_W-1:0]   acc_i_d, acc_i_q, acc_q_d, acc_q_q, sum_i, sum_q;
   logic signed [OUT_W-1:0]   i_out_d, i_out_q, q_out_d, q_out_q;
   logic        [CNT_W-1:0]   dec_cnt_d, dec_cnt_q, cnt_eff;

   assign phase = sync ? '0 : phase_acc_q;

   ddc_sincos_lut #(.PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .LO_W(LO_W)) u_lut (
      .phase (phase),
      .cos_o (lut_cos),
      .sin_o (lut_sin)
   );

   always_comb begin
      phase_acc_d   = phase_acc_q;
      phase_inc_r_d = freq_load ? phase_inc : phase_inc_r_q;
      if1_d = if1_q;  cos1_d = cos1_q;  sin1_d = sin1_q;  first1_d = first1_q;
      pi2_d = pi2_q;  pq2_d  = pq2_q;   first2_d = first2_q;
      acc_i_d = acc_i_q;  acc_q_d = acc_q_q;  dec_cnt_d = dec_cnt_q;
      i_out_d = i_out_q;  q_out_d = q_out_q;
      v1_d = in_valid;  v2_d = v1_q;  out_valid_d = 1'b0;

      if (in_valid) begin
         phase_acc_d = phase + phase_inc_r_q;
         if1_d    = if_in;
         cos1_d   = lut_cos;
         sin1_d   = lut_sin;
         first1_d = sync;
      end

      if (v1_q) begin
         pi2_d    = PW'(if1_q) * PW'(cos1_q);
         pq2_d    = PW'(if1_q) * PW'(sin1_q);
         first2_d = first1_q;
      end

      // A sync sample restarts the group, silently dropping any partial sum.
      cnt_eff = first2_q ? '0 : dec_cnt_q;
      sum_i   = (cnt_eff == '0) ? OUT_W'(pi2_q) : acc_i_q + OUT_W'(pi2_q);
      sum_q   = (cnt_eff == '0) ? OUT_W'(pq2_q) : acc_q_q + OUT_W'(pq2_q);

      if (v2_q) begin
         if (cnt_eff == CNT_W'(DEC - 1)) begin
            i_out_d     = sum_i;
            q_out_d     = sum_q;
            out_valid_d = 1'b1;
            dec_cnt_d   = '0;
         end else begin
            acc_i_d   = sum_i;
            acc_q_d   = sum_q;
            dec_cnt_d = cnt_eff + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_acc_q <= '0;  phase_inc_r_q <= '0;
         if1_q <= '0;  cos1_q <= '0;  sin1_q <= '0;  first1_q <= 1'b0;
         pi2_q <= '0;  pq2_q  <= '0;  first2_q <= 1'b0;
         acc_i_q <= '0;  acc_q_q <= '0;  dec_cnt_q <= '0;
         i_out_q <= '0;  q_out_q <= '0;
         v1_q <= 1'b0;  v2_q <= 1'b0;  out_valid_q <= 1'b0;
      end else begin
         phase_acc_q <= phase_acc_d;  phase_inc_r_q <= phase_inc_r_d;
         if1_q <= if1_d;  cos1_q <= cos1_d;  sin1_q <= sin1_d;  first1_q <= first1_d;
         pi2_q <= pi2_d;  pq2_q  <= pq2_d;   first2_q <= first2_d;
         acc_i_q <= acc_i_d;  acc_q_q <= acc_q_d;  dec_cnt_q <= dec_cnt_d;
         i_out_q <= i_out_d;  q_out_q <= q_out_d;
         v1_q <= v1_d;  v2_q <= v2_d;  out_valid_q <= out_valid_d;
      end
   end

   assign I_out     = i_out_q;
   assign Q_out     = q_out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ddc_nco_mixer.sv
// Directed bench for ddc_nco_mixer: a behavioural NCO/mixer model queues the
// expected dump (value and cycle) per group; a monitor pops on out_valid.
module tb_ddc_nco_mixer;

   localparam int OW = 18;

   logic                 clk = 1'b0, rst_n = 1'b0;
   logic                 in_valid = 1'b0, freq_load = 1'b0, sync = 1'b0;
   logic signed [7:0]    if_in = '0;
   logic        [15:0]   phase_inc = '0;
   logic signed [OW-1:0] I_out, Q_out;
   logic                 out_valid;

   ddc_nco_mixer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .if_in     (if_in),
      .phase_inc (phase_inc),
      .freq_load (freq_load),
      .sync      (sync),
      .I_out     (I_out),
      .Q_out     (Q_out),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { longint i; longint q; int at; } exp_t;
   exp_t   sb[$];
   exp_t   mon_e;
   int     total = 0, bad = 0;

   logic [15:0] m_acc = '0, m_inc = '0;
   int          m_cnt = 0;
   longint      m_si = 0, m_sq = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int tq(input int k);
      return $rtoi(127.0 * $sin(3.141592653589793 * k / 128.0) + 0.5);
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) chk("unexpected_dump", 1, 0);
         else begin
            mon_e = sb.pop_front();
            chk("I_out", I_out, mon_e.i);
            chk("Q_out", Q_out, mon_e.q);
            chk("dump_cycle", cyc, mon_e.at);
         end
      end
   end

   task automatic model_reset();
      m_acc = '0; m_inc = '0; m_cnt = 0; m_si = 0; m_sq = 0;
   endtask

   task automatic smp(input int x, input bit sy, input bit fl = 1'b0, input logic [15:0] inc = '0);
      logic [15:0] ph;
      int c, s, k, kn;
      @(negedge clk);
      in_valid = 1'b1; if_in = 8'(x); sync = sy; freq_load = fl; phase_inc = inc;
      ph    = sy ? 16'h0 : m_acc;
      m_acc = ph + m_inc;
      if (fl) m_inc = inc;
      k  = int'(ph[13:8]);
      kn = 64 - k;
      case (ph[15:14])
         2'd0: begin s = tq(k);   c = tq(kn);  end
         2'd1: begin s = tq(kn);  c = -tq(k);  end
         2'd2: begin s = -tq(k);  c = -tq(kn); end
         default: begin s = -tq(kn); c = tq(k); end
      endcase
      if (sy) m_cnt = 0;
      if (m_cnt == 0) begin m_si = x * c; m_sq = x * s; end
      else begin m_si += x * c; m_sq += x * s; end
      if (m_cnt == 3) begin
         sb.push_back('{m_si, m_sq, cyc + 3});
         m_cnt = 0;
      end else m_cnt++;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0; sync = 1'b0; freq_load = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic load(input logic [15:0] inc);
      @(negedge clk);
      in_valid = 1'b0; sync = 1'b0; freq_load = 1'b1; phase_inc = inc;
      m_inc = inc;
      @(negedge clk);
      freq_load = 1'b0;
   endtask

   task automatic drain(input string tag);
      idle(1);
      for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
      chk({tag, "_drained"}, sb.size(), 0);
   endtask

   int pat [8] = '{37, -90, 55, -12, 120, -128, 7, -66};

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_I", I_out, 0);
      chk("rst_Q", Q_out, 0);
      chk("rst_valid", out_valid, 0);
      rst_n = 1'b1;

      // 1: reset mid-group, then a clean group at phase 0
      smp(100, 0); smp(100, 0);
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      chk("midrst_I", I_out, 0);
      chk("midrst_valid", out_valid, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) smp(100, 0);
      drain("t1");

      // 2/3: quarter-rate LO
      load(16'h4000);
      smp(100, 1); smp(100, 0); smp(100, 0); smp(100, 0);
      smp(100, 1); smp(0, 0); smp(-100, 0); smp(0, 0);
      smp(0, 1); smp(100, 0); smp(0, 0); smp(-100, 0);
      drain("t23");

      // 4: most negative input, phase held at 0
      load(16'h0000);
      smp(-128, 1); smp(-128, 0); smp(-128, 0); smp(-128, 0);
      drain("t4");

      // 5: arbitrary tuning, freq_load with a sample, gapless then gapped
      load(16'h1234);
      for (int i = 0; i < 8; i++) smp(pat[i], i == 0, i == 2, 16'h2345);
      drain("t5a");
      load(16'h1234);
      for (int i = 0; i < 8; i++) begin
         smp(pat[i], i == 0, i == 2, 16'h2345);
         idle(2);
      end
      drain("t5b");

      // 6: sync on the third sample breaks the group
      load(16'h4000);
      smp(100, 1); smp(50, 0); smp(-70, 1); smp(20, 0); smp(90, 0); smp(-30, 0);
      drain("t6");

      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
